// File: rtl/ext_pkg.sv
// Shared encodings for the immediate-extension pipeline: operand modes and skid-buffer states.
// The upper-load mode is only honoured when EXT_UPPER_EN is defined (see ext_pipe).
package ext_pkg;

    typedef logic [1:0] ext_mode_t;
    typedef logic [1:0] buf_state_t;

    localparam ext_mode_t EXT_ZERO  = 2'd0;
    localparam ext_mode_t EXT_SIGN  = 2'd1;
    localparam ext_mode_t EXT_UPPER = 2'd2;
    localparam ext_mode_t EXT_RSVD  = 2'd3;

    localparam buf_state_t ST_EMPTY = 2'd0;
    localparam buf_state_t ST_ONE   = 2'd1;
    localparam buf_state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/ext_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: registered outputs always come from the main entry,
// the skid entry catches the one extra word accepted while the consumer stalls.
module ext_skid_buf
    import ext_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t     state_q, state_d;
    logic [W-1:0]   main_q, main_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           push, pop;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    main_d  = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_d = in_data;
                end else if (push) begin
                    skid_d  = in_data;
                    state_d = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a pop can move the buffer
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate extender (zero / sign / optional upper-load) behind a 2-entry skid buffer.
// Define EXT_UPPER_EN to enable upper-load; otherwise mode 2 behaves like the reserved mode.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    if (OUT_W <= IN_W) begin : g_bad_width
        $error("ext_pipe: OUT_W must be greater than IN_W");
    end

    // Result word is {err, data}; illegal modes yield zero data with err set
    function automatic logic [OUT_W:0] extend_operand(input logic [IN_W-1:0] d,
                                                      input ext_mode_t mode);
        logic [OUT_W:0] r;
        r = {1'b1, {OUT_W{1'b0}}};
        case (mode)
            EXT_ZERO:  r = {1'b0, {(OUT_W-IN_W){1'b0}}, d};
            EXT_SIGN:  r = {1'b0, {(OUT_W-IN_W){d[IN_W-1]}}, d};
`ifdef EXT_UPPER_EN
            EXT_UPPER: r = {1'b0, d, {(OUT_W-IN_W){1'b0}}};
`endif
            default:   r = {1'b1, {OUT_W{1'b0}}};
        endcase
        return r;
    endfunction

    logic [OUT_W:0] ext_word;
    logic [OUT_W:0] buf_word;

    always_comb begin
        ext_word = extend_operand(in_data, in_mode);
    end

    ext_skid_buf #(
        .W (OUT_W + 1)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (ext_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_word)
    );

    assign out_data = buf_word[OUT_W-1:0];
    assign out_err  = buf_word[OUT_W];

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed literal cases plus random valid/ready traffic
// checked against a queue-based model of a 2-deep in-order buffer.
module tb_ext_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_pops       = 0;

    logic [OUT_W:0] model_q[$];
    logic           stall_prev = 1'b0;
    logic [OUT_W:0] held_word  = '0;

    ext_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension by plain arithmetic; returns {err, data}
    function automatic logic [OUT_W:0] model_ext(input logic [IN_W-1:0] d, input logic [1:0] m);
        longint v;
        logic   err;
        v   = 0;
        err = 1'b0;
        v[IN_W-1:0] = d;
        if (m == 2'd1) begin
            if (d[IN_W-1]) v = v - (longint'(1) << IN_W);
        end else if (m == 2'd2) begin
`ifdef EXT_UPPER_EN
            v = v << (OUT_W - IN_W);
`else
            v   = 0;
            err = 1'b1;
`endif
        end else if (m == 2'd3) begin
            v   = 0;
            err = 1'b1;
        end
        v = v & ((longint'(1) << OUT_W) - 1);
        return {err, v[OUT_W-1:0]};
    endfunction

    // Compare process: checks DUT against the model mid-cycle, then applies the coming edge's transfers
    always @(negedge clk) begin
        logic [OUT_W:0] front;
        logic           do_push, do_pop;
        if (rst) begin
            model_q.delete();
            stall_prev = 1'b0;
            checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        end else begin
            checkOutput("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
            checkOutput("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
            if (model_q.size() != 0) begin
                front = model_q[0];
                checkOutput("out_data", 64'(out_data), 64'(front[OUT_W-1:0]));
                checkOutput("out_err", 64'(out_err), 64'(front[OUT_W]));
            end
            if (stall_prev) checkOutput("stall_hold", 64'({out_err, out_data}), 64'(held_word));
            stall_prev = (model_q.size() != 0) && !out_ready;
            held_word  = {out_err, out_data};
            do_pop  = (model_q.size() != 0) && out_ready;
            do_push = in_valid && (model_q.size() < 2);
            if (do_pop) begin
                void'(model_q.pop_front());
                n_pops++;
            end
            if (do_push) model_q.push_back(model_ext(in_data, in_mode));
        end
    end

    // Single push with the consumer ready; result checked against a literal one edge later
    task automatic applyStimulus(input string name, input logic [IN_W-1:0] d, input logic [1:0] m,
                                 input logic [OUT_W-1:0] exp_data, input logic exp_err);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput({name, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({name, "_data"}, 64'(out_data), 64'(exp_data));
        checkOutput({name, "_err"}, 64'(out_err), 64'(exp_err));
    endtask

    initial begin
        int start_pops;
        int cycles;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'd0;
        out_ready = 1'b0;
        #2;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_out_err", 64'(out_err), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        applyStimulus("sign_8000", 16'h8000, 2'd1, 32'hFFFF_8000, 1'b0);
        applyStimulus("zero_8000", 16'h8000, 2'd0, 32'h0000_8000, 1'b0);
        applyStimulus("sign_7fff", 16'h7FFF, 2'd1, 32'h0000_7FFF, 1'b0);
`ifdef EXT_UPPER_EN
        applyStimulus("upper_ffff", 16'hFFFF, 2'd2, 32'hFFFF_0000, 1'b0);
`else
        applyStimulus("upper_ffff", 16'hFFFF, 2'd2, 32'h0000_0000, 1'b1);
`endif
        applyStimulus("rsvd_1234", 16'h1234, 2'd3, 32'h0000_0000, 1'b1);
        repeat (2) @(posedge clk);

        // Back-pressure: two accepted, third waits, order preserved
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        in_data   = 16'h0001;
        @(posedge clk);
        #1;
        in_data = 16'h0002;
        @(posedge clk);
        #1;
        checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
        in_data = 16'h0003;
        @(posedge clk);
        #1;
        checkOutput("bp_still_full", 64'(in_ready), 64'd0);
        checkOutput("bp_hold_first", 64'(out_data), 64'h1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_second", 64'(out_data), 64'h2);
        checkOutput("bp_ready_back", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_third", 64'(out_data), 64'h3);
        @(posedge clk);
        #1;
        checkOutput("bp_drained", 64'(out_valid), 64'd0);

        // Continuous streaming: no bubbles, in_ready never drops
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = IN_W'($urandom);
            in_mode = 2'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
            checkOutput("stream_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset while full
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd1;
        in_data   = 16'hAAAA;
        @(posedge clk);
        #1;
        in_data = 16'h5555;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("full_before_rst", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_rst_out_data", 64'(out_data), 64'd0);
        checkOutput("async_rst_out_err", 64'(out_err), 64'd0);
        checkOutput("async_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_no_stale", 64'(out_valid), 64'd0);
        end

        // Random traffic: 1000 pops with random valid/ready and modes
        start_pops = n_pops;
        cycles     = 0;
        while ((n_pops - start_pops) < 1000 && cycles < 20000) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = IN_W'($urandom);
            in_mode   = 2'($urandom_range(0, 3));
            cycles++;
        end
        checkOutput("random_transfers_done", 64'((n_pops - start_pops) >= 1000), 64'd1);

        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("final_drained", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
